lut_sweep_eval: RTL and testbench

- Parametrised, registered successor to our fixed 4-input gate-level truth-table functions.
- Holds a runtime-writable 2^N_IN-entry truth table and evaluates it over a valid/ready stream.
- Has a self-test sweep mode that walks every input code, streams each result, and reports the count of ones.
- Sits between stimulus/config logic and any consumer of a single-bit Boolean function.

---
 rtl/lut_sweep_eval.sv | 126 ++++++++++++
 tb/tb_lut_sweep_eval.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_sweep_eval.sv
// Runtime-writable 2^N_IN-entry truth table evaluated over a valid/ready stream,
// with a sweep mode that streams every entry and counts the ones.
module lut_sweep_eval #(
  parameter int                   N_IN       = 4,
  parameter logic [(1<<N_IN)-1:0] DEFAULT_TT = 16'h0AC5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [N_IN-1:0] cfg_addr,
  input  logic            cfg_bit,
  output logic            cfg_err,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N_IN-1:0] out_x,
  output logic            out_z,
  output logic            out_last,
  input  logic            sweep_start,
  output logic            sweep_busy,
  output logic            sweep_done,
  output logic [N_IN:0]   sweep_ones
);
  localparam int DEPTH = 1 << N_IN;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t            state_reg, state_next;
  logic [DEPTH-1:0]  table_reg, table_next;
  logic [N_IN:0]     cnt_reg;
  logic [N_IN:0]     ones_reg;
  logic              out_valid_reg, out_z_reg, out_last_reg, cfg_err_reg;
  logic [N_IN-1:0]   out_x_reg;
  logic              busy, out_free, in_fire, sweep_issue, last_xfer;
  logic              table_we, sweep_enter;

  assign busy        = (state_reg != IDLE);
  assign out_free    = ~out_valid_reg | out_ready;
  // in_ready is held low while reset is asserted so every output reads 0
  assign in_ready    = rst_n & ~busy & out_free;
  assign in_fire     = in_valid & in_ready;
  // cnt_reg[N_IN] marks that every code has been issued
  assign sweep_issue = (state_reg == SWEEP) & out_free & ~cnt_reg[N_IN];
  assign last_xfer   = out_valid_reg & out_ready & out_last_reg;
  assign table_we    = cfg_we & (state_reg == IDLE);

  always_comb begin
    table_next = table_reg;
    if (table_we) table_next[cfg_addr] = cfg_bit;
  end

  always_comb begin
    state_next  = state_reg;
    sweep_enter = 1'b0;
    case (state_reg)
      IDLE: begin
        // a start pulse that collides with an accepted evaluation is dropped
        if (sweep_start && !in_fire) begin
          state_next  = SWEEP;
          sweep_enter = 1'b1;
        end
      end
      SWEEP:   if (last_xfer) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      table_reg <= DEFAULT_TT;
    end else begin
      state_reg <= state_next;
      table_reg <= table_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      ones_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_x_reg     <= '0;
      out_z_reg     <= 1'b0;
      out_last_reg  <= 1'b0;
      cfg_err_reg   <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_we & busy;

      if (sweep_enter) begin
        cnt_reg  <= '0;
        ones_reg <= '0;
      end else if (sweep_issue) begin
        cnt_reg  <= cnt_reg + 1'b1;
        ones_reg <= ones_reg + {{N_IN{1'b0}}, table_reg[cnt_reg[N_IN-1:0]]};
      end

      // table is read before this cycle's write lands (pre-write semantics)
      if (in_fire) begin
        out_valid_reg <= 1'b1;
        out_x_reg     <= in_x;
        out_z_reg     <= table_reg[in_x];
        out_last_reg  <= 1'b0;
      end else if (sweep_issue) begin
        out_valid_reg <= 1'b1;
        out_x_reg     <= cnt_reg[N_IN-1:0];
        out_z_reg     <= table_reg[cnt_reg[N_IN-1:0]];
        out_last_reg  <= (cnt_reg[N_IN-1:0] == {N_IN{1'b1}});
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign cfg_err    = cfg_err_reg;
  assign out_valid  = out_valid_reg;
  assign out_x      = out_x_reg;
  assign out_z      = out_z_reg;
  assign out_last   = out_last_reg;
  assign sweep_busy = busy;
  assign sweep_done = (state_reg == DONE);
  assign sweep_ones = ones_reg;
endmodule

// File: tb/tb_lut_sweep_eval.sv
// Self-checking bench for lut_sweep_eval: vector table, hand sequences, random
// traffic against a queue/array reference model, and sweep checks.
module tb_lut_sweep_eval;
  localparam int N = 4;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_we = 1'b0;
  logic [N-1:0] cfg_addr = '0;
  logic         cfg_bit = 1'b0;
  logic         cfg_err;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_x = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_x;
  logic         out_z;
  logic         out_last;
  logic         sweep_start = 1'b0;
  logic         sweep_busy;
  logic         sweep_done;
  logic [N:0]   sweep_ones;

  int   total = 0;
  int   bad = 0;
  logic tt [D];

  typedef struct {
    logic [N-1:0] x;
    logic         z;
  } vec_t;

  typedef struct {
    int x;
    int z;
  } beat_t;

  always #5 clk = ~clk;

  lut_sweep_eval #(.N_IN(N), .DEFAULT_TT(16'h0AC5)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_bit(cfg_bit), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_z(out_z),
    .out_last(out_last),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .sweep_ones(sweep_ones)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_default();
    logic [15:0] d;
    d = 16'h0AC5;
    for (int i = 0; i < D; i++) tt[i] = d[i];
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " out_x"}, out_x, 0);
    check({tag, " out_z"}, out_z, 0);
    check({tag, " out_last"}, out_last, 0);
    check({tag, " in_ready"}, in_ready, 0);
    check({tag, " cfg_err"}, cfg_err, 0);
    check({tag, " sweep_busy"}, sweep_busy, 0);
    check({tag, " sweep_done"}, sweep_done, 0);
    check({tag, " sweep_ones"}, sweep_ones, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cfg_we = 1'b0; in_valid = 1'b0; sweep_start = 1'b0; out_ready = 1'b0;
    #1;
    check_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("post-reset in_ready", in_ready, 1);
    model_default();
  endtask

  task automatic cfg_write(input int addr, input logic b);
    cfg_we = 1'b1; cfg_addr = N'(addr); cfg_bit = b;
    tick();
    cfg_we = 1'b0;
    tt[addr] = b;
  endtask

  // Streams one sweep and checks every beat against the expected code order.
  task automatic run_sweep(input string tag, input bit rand_ready, input bit poke, input int pend_x);
    int  exp_x[$];
    int  exp_ones, beats, errs, want_beats, hx;
    bit  prev_last, done_seen;
    exp_ones = 0; beats = 0; errs = 0; prev_last = 0; done_seen = 0;
    for (int i = 0; i < D; i++) if (tt[i]) exp_ones++;
    if (pend_x >= 0) begin
      out_ready = 1'b0; in_valid = 1'b1; in_x = N'(pend_x);
      tick();
      in_valid = 1'b0;
      exp_x.push_back(pend_x);
    end
    for (int i = 0; i < D; i++) exp_x.push_back(i);
    want_beats = exp_x.size();
    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      out_ready   = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      sweep_start = (cyc == 0) || (poke && cyc == 5);
      cfg_we      = poke && cyc == 5;
      cfg_addr    = '0;
      cfg_bit     = 1'b0;
      #1;
      if (cfg_err) errs++;
      if (cyc == 1) begin
        check({tag, " busy at start"}, sweep_busy, 1);
        check({tag, " ones cleared"}, sweep_ones, 0);
      end
      check({tag, " done timing"}, sweep_done, prev_last);
      prev_last = 0;
      if (sweep_done) begin
        done_seen = 1;
        check({tag, " sweep_ones"}, sweep_ones, exp_ones);
        check({tag, " beat count"}, beats, want_beats);
        check({tag, " busy in done"}, sweep_busy, 1);
      end else if (out_valid && out_ready) begin
        beats++;
        if (exp_x.size() == 0) begin
          check({tag, " extra beat"}, 1, 0);
        end else begin
          hx = exp_x.pop_front();
          $display("%s beat x=%0d z=%0d last=%0d", tag, out_x, out_z, out_last);
          check({tag, " beat out_x"}, out_x, hx);
          check({tag, " beat out_z"}, out_z, tt[hx]);
          check({tag, " beat out_last"}, out_last, (beats == want_beats) ? 1 : 0);
          prev_last = (beats == want_beats);
        end
      end
      tick();
    end
    sweep_start = 1'b0; cfg_we = 1'b0;
    if (!done_seen) check({tag, " sweep_done timeout"}, 0, 1);
    check({tag, " cfg_err pulses"}, errs, poke ? 1 : 0);
    for (int k = 0; k < 3; k++) begin
      check({tag, " idle busy"}, sweep_busy, 0);
      check({tag, " idle done"}, sweep_done, 0);
      tick();
    end
    $display("%s sweep ones=%0d beats=%0d", tag, sweep_ones, beats);
  endtask

  initial begin
    vec_t  vecs [D];
    beat_t q[$];
    beat_t b;
    bit    exp_rdy, found;

    for (int i = 0; i < D; i++) begin
      vecs[i].x = N'(i);
      vecs[i].z = (i inside {0, 2, 6, 7, 9, 11});
    end

    do_reset();

    // Plain evaluation of the default table, back to back
    out_ready = 1'b1;
    for (int i = 0; i < D; i++) begin
      in_valid = 1'b1; in_x = vecs[i].x;
      #1;
      check("eval in_ready", in_ready, 1);
      tick();
      $display("eval x=%0d z=%0d last=%0d", out_x, out_z, out_last);
      check("eval out_valid", out_valid, 1);
      check("eval out_x", out_x, vecs[i].x);
      check("eval out_z", out_z, vecs[i].z);
      check("eval out_last", out_last, 0);
    end
    in_valid = 1'b0;
    tick();
    check("eval drained", out_valid, 0);

    // Table write, then pre-write read of the same address
    cfg_write(4, 1'b1);
    in_valid = 1'b1; in_x = 4'd4;
    tick();
    check("wr4 out_z", out_z, 1);
    cfg_we = 1'b1; cfg_addr = 4'd2; cfg_bit = 1'b0; in_x = 4'd2;
    tick();
    cfg_we = 1'b0; tt[2] = 1'b0;
    check("prewrite out_z", out_z, 1);
    tick();
    check("postwrite out_z", out_z, 0);
    in_valid = 1'b0;
    tick();

    // Backpressure holds the result and blocks new requests
    out_ready = 1'b0; in_valid = 1'b1; in_x = 4'd9;
    tick();
    in_x = 4'd3;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall in_ready", in_ready, 0);
      check("stall out_valid", out_valid, 1);
      check("stall out_x", out_x, 9);
      check("stall out_z", out_z, 1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("unstall in_ready", in_ready, 1);
    tick();
    check("unstall out_x", out_x, 3);
    check("unstall out_z", out_z, tt[3]);
    in_valid = 1'b0;
    tick();
    check("unstall drained", out_valid, 0);

    // Random traffic against a one-deep queue model of the output register
    for (int c = 0; c < 300; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_x      = N'($urandom_range(0, D - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_addr  = N'($urandom_range(0, D - 1));
      cfg_bit   = ($urandom_range(0, 1) == 1);
      #1;
      exp_rdy = (q.size() == 0) || out_ready;
      check("rnd in_ready", in_ready, exp_rdy);
      check("rnd out_valid", out_valid, (q.size() != 0) ? 1 : 0);
      if (q.size() != 0 && out_valid) begin
        check("rnd out_x", out_x, q[0].x);
        check("rnd out_z", out_z, q[0].z);
      end
      check("rnd cfg_err", cfg_err, 0);
      if (out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && exp_rdy) begin
        b.x = int'(in_x);
        b.z = int'(tt[in_x]);
        q.push_back(b);
      end
      if (cfg_we) tt[cfg_addr] = cfg_bit;
      tick();
    end
    cfg_we = 1'b0; in_valid = 1'b0;
    $display("random phase done");

    // Sweeps on the default table
    do_reset();
    run_sweep("sweep_full", 1'b0, 1'b0, -1);
    run_sweep("sweep_rand", 1'b1, 1'b0, -1);
    run_sweep("sweep_poke", 1'b0, 1'b1, -1);
    run_sweep("sweep_after_poke", 1'b1, 1'b0, -1);
    run_sweep("sweep_pending", 1'b1, 1'b0, 5);

    // Reset in the middle of a sweep on a modified table
    cfg_write(1, 1'b1);
    out_ready = 1'b1; sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid && out_x == 4'd7) begin
        found = 1;
        break;
      end
      tick();
    end
    check("abort found beat 7", found, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    tick();
    tick();
    rst_n = 1'b1;
    model_default();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("abort no done", sweep_done, 0);
      check("abort idle", sweep_busy, 0);
    end
    run_sweep("sweep_restored", 1'b0, 1'b0, -1);
    check("restored ones", sweep_ones, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
